parking_gate_detector: RTL and testbench



---
 rtl/parking_gate_detector.sv | 181 ++++++++++++++++++
 tb/tb_parking_gate_detector.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_detector.sv
// Gate-side entry/exit detector: synchronizes and debounces two beam sensors, then emits inc/dec/err pulses.
// Optional stall timer is enabled by defining GATE_TIMEOUT_EN.
module parking_gate_detector #(
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE    = 4,
   parameter int TIMEOUT     = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic sens_a,
   input  logic sens_b,
   output logic inc,
   output logic dec,
   output logic err,
   output logic busy
);

   localparam int CNT_W = $clog2(DEBOUNCE + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

   typedef enum logic [2:0] {
      IDLE, EN1, EN2, EN3, EX1, EX2, EX3, WAIT_CLR
   } state_t;

   logic [SYNC_STAGES-1:0] sync_a_q, sync_b_q;
   logic [1:0]             s;
   logic [1:0]             cand_q, filt_q;
   logic [CNT_W-1:0]       cnt_q;
   state_t                 state_q, state_d;
   logic                   inc_q, dec_q, err_q, busy_q;
   logic                   inc_d, dec_d, err_d;
   logic                   in_path;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_a_q <= '0;
         sync_b_q <= '0;
      end else begin
         sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], sens_a};
         sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], sens_b};
      end
   end

   assign s = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};

   // Accept a sensor pair only after it has been stable for DEBOUNCE cycles
   always_ff @(posedge clk) begin
      if (reset) begin
         cand_q <= 2'b00;
         filt_q <= 2'b00;
         cnt_q  <= '0;
      end else if (s != cand_q) begin
         cand_q <= s;
         cnt_q  <= '0;
      end else if (cnt_q == CNT_MAX) begin
         filt_q <= cand_q;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign in_path = (state_q != IDLE) && (state_q != WAIT_CLR);

`ifdef GATE_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT - 1);
   logic [TMR_W-1:0] tmr_q;
   logic             stall;

   assign stall = in_path && (tmr_q == TMR_MAX);

   always_ff @(posedge clk) begin
      if (reset || (state_d != state_q)) begin
         tmr_q <= '0;
      end else if (in_path) begin
         tmr_q <= tmr_q + 1'b1;
      end
   end
`else
   logic stall;
   assign stall = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      inc_d   = 1'b0;
      dec_d   = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            case (filt_q)
               2'b10:   state_d = EN1;
               2'b01:   state_d = EX1;
               2'b11:   begin state_d = WAIT_CLR; err_d = 1'b1; end
               default: state_d = IDLE;
            endcase
         end
         EN1: begin
            case (filt_q)
               2'b10:   state_d = EN1;
               2'b11:   state_d = EN2;
               2'b00:   state_d = IDLE;
               default: err_d = 1'b1;
            endcase
         end
         EN2: begin
            case (filt_q)
               2'b11:   state_d = EN2;
               2'b01:   state_d = EN3;
               2'b10:   state_d = EN1;
               default: err_d = 1'b1;
            endcase
         end
         EN3: begin
            case (filt_q)
               2'b01:   state_d = EN3;
               2'b00:   begin state_d = IDLE; inc_d = 1'b1; end
               2'b11:   state_d = EN2;
               default: err_d = 1'b1;
            endcase
         end
         EX1: begin
            case (filt_q)
               2'b01:   state_d = EX1;
               2'b11:   state_d = EX2;
               2'b00:   state_d = IDLE;
               default: err_d = 1'b1;
            endcase
         end
         EX2: begin
            case (filt_q)
               2'b11:   state_d = EX2;
               2'b10:   state_d = EX3;
               2'b01:   state_d = EX1;
               default: err_d = 1'b1;
            endcase
         end
         EX3: begin
            case (filt_q)
               2'b10:   state_d = EX3;
               2'b00:   begin state_d = IDLE; dec_d = 1'b1; end
               2'b11:   state_d = EX2;
               default: err_d = 1'b1;
            endcase
         end
         WAIT_CLR: begin
            if (filt_q == 2'b00) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Illegal path transitions and stalls both abandon the car without counting it
      if (err_d || (stall && (state_d == state_q))) begin
         err_d   = 1'b1;
         inc_d   = 1'b0;
         dec_d   = 1'b0;
         state_d = (filt_q == 2'b00) ? IDLE : WAIT_CLR;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         inc_q   <= 1'b0;
         dec_q   <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         inc_q   <= inc_d;
         dec_q   <= dec_d;
         err_q   <= err_d;
         busy_q  <= (state_d != IDLE);
      end
   end

   assign inc  = inc_q;
   assign dec  = dec_q;
   assign err  = err_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_parking_gate_detector.sv
// Directed bench for parking_gate_detector; define GATE_TIMEOUT_EN to exercise the stall timer.
module tb_parking_gate_detector;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic sens_a = 1'b0;
   logic sens_b = 1'b0;
   logic inc, dec, err, busy;

   int n_cmp = 0;
   int n_mis = 0;
   int n_inc = 0, n_dec = 0, n_err = 0, n_busy = 0, n_ovl = 0, n_wide = 0;
   int b_inc, b_dec, b_err, b_busy;
   logic p_inc = 1'b0, p_dec = 1'b0, p_err = 1'b0;

   parking_gate_detector #(.SYNC_STAGES(2), .DEBOUNCE(4), .TIMEOUT(50)) dut (
      .clk(clk), .reset(reset), .sens_a(sens_a), .sens_b(sens_b),
      .inc(inc), .dec(dec), .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   // Pulse statistics, sampled just after each rising edge
   always @(posedge clk) begin
      #1;
      if (inc) n_inc++;
      if (dec) n_dec++;
      if (err) n_err++;
      if (busy) n_busy++;
      if ((int'(inc) + int'(dec) + int'(err)) > 1) n_ovl++;
      if ((inc && p_inc) || (dec && p_dec) || (err && p_err)) n_wide++;
      p_inc = inc;
      p_dec = dec;
      p_err = err;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic a, input logic b, input int n);
      sens_a = a;
      sens_b = b;
      repeat (n) @(negedge clk);
   endtask

   task automatic snap();
      b_inc  = n_inc;
      b_dec  = n_dec;
      b_err  = n_err;
      b_busy = n_busy;
   endtask

   task automatic chk_counts(input string tag, input int ei, input int ed, input int ee);
      chk({tag, "_inc_cnt"}, n_inc - b_inc, ei);
      chk({tag, "_dec_cnt"}, n_dec - b_dec, ed);
      chk({tag, "_err_cnt"}, n_err - b_err, ee);
   endtask

   // Release both beams and check the registered pulse lands exactly 7 edges after the sample
   task automatic final_pulse(input string tag, input logic [2:0] exp);
      drive(1'b0, 1'b0, 7);
      chk({tag, "_pre"}, {inc, dec, err}, 3'b000);
      @(negedge clk);
      chk({tag, "_pulse"}, {inc, dec, err}, exp);
      @(negedge clk);
      chk({tag, "_post"}, {inc, dec, err}, 3'b000);
      chk({tag, "_busy"}, busy, 1'b0);
   endtask

   initial begin
      @(negedge clk);
      repeat (3) @(negedge clk);
      chk("reset_outs", {inc, dec, err, busy}, 4'b0000);
      reset = 1'b0;

      // Idle sensors
      snap();
      drive(1'b0, 1'b0, 20);
      chk_counts("idle", 0, 0, 0);
      chk("idle_busy_cnt", n_busy - b_busy, 0);

      // Entry
      snap();
      drive(1'b1, 1'b0, 10);
      chk("entry_busy", busy, 1'b1);
      drive(1'b1, 1'b1, 10);
      drive(1'b0, 1'b1, 10);
      final_pulse("entry", 3'b100);
      drive(1'b0, 1'b0, 5);
      chk_counts("entry", 1, 0, 0);

      // Exit followed by another entry
      snap();
      drive(1'b0, 1'b1, 10);
      drive(1'b1, 1'b1, 10);
      drive(1'b1, 1'b0, 10);
      final_pulse("exit", 3'b010);
      @(negedge clk);
      chk("between_busy", busy, 1'b0);
      drive(1'b1, 1'b0, 10);
      drive(1'b1, 1'b1, 10);
      drive(1'b0, 1'b1, 10);
      final_pulse("entry2", 3'b100);
      drive(1'b0, 1'b0, 5);
      chk_counts("exit_entry", 1, 1, 0);

      // Aborted entry
      snap();
      drive(1'b1, 1'b0, 10);
      drive(1'b1, 1'b1, 10);
      drive(1'b1, 1'b0, 10);
      final_pulse("abort", 3'b000);
      chk_counts("abort", 0, 0, 0);

      // Short glitch on A never reaches the filtered pair
      snap();
      drive(1'b1, 1'b0, 3);
      drive(1'b0, 1'b0, 20);
      chk_counts("glitch", 0, 0, 0);
      chk("glitch_busy_cnt", n_busy - b_busy, 0);

      // Illegal jump straight to both blocked
      snap();
      drive(1'b1, 1'b1, 7);
      chk("illegal_pre", {err, busy}, 2'b00);
      @(negedge clk);
      chk("illegal_err", {inc, dec, err, busy}, 4'b0011);
      drive(1'b1, 1'b1, 20);
      chk("illegal_hold_busy", busy, 1'b1);
      drive(1'b0, 1'b0, 7);
      chk("illegal_clr_pre", busy, 1'b1);
      @(negedge clk);
      chk("illegal_clr", busy, 1'b0);
      drive(1'b0, 1'b0, 5);
      chk_counts("illegal", 0, 0, 1);

      // Reset in the middle of an entry
      snap();
      drive(1'b1, 1'b0, 10);
      chk("midrst_busy", busy, 1'b1);
      drive(1'b1, 1'b1, 4);
      reset = 1'b1;
      drive(1'b0, 1'b0, 2);
      chk("midrst_outs", {inc, dec, err, busy}, 4'b0000);
      reset = 1'b0;
      drive(1'b0, 1'b0, 15);
      chk_counts("midrst", 0, 0, 0);
      chk("midrst_busy_after", busy, 1'b0);

      // Long hold on the outer beam
      snap();
`ifdef GATE_TIMEOUT_EN
      drive(1'b1, 1'b0, 57);
      chk("timeout_pre", err, 1'b0);
      @(negedge clk);
      chk("timeout_err", {inc, dec, err, busy}, 4'b0011);
      drive(1'b1, 1'b0, 42);
      chk("timeout_wait_busy", busy, 1'b1);
      final_pulse("timeout_clr", 3'b000);
      chk_counts("timeout", 0, 0, 1);
`else
      drive(1'b1, 1'b0, 100);
      chk("hold_busy", busy, 1'b1);
      final_pulse("hold_clr", 3'b000);
      chk_counts("hold", 0, 0, 0);
`endif

      chk("overlap_cnt", n_ovl, 0);
      chk("wide_pulse_cnt", n_wide, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
